// File: rtl/timer.sv
// Loadable, saturating down-counter with one-cycle expiry pulse.
// Load has priority over count enable; reaching zero by decrement raises expired_o for one cycle.
module timer #(
    parameter int unsigned          WIDTH   = 4,
    parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] init_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zero_o,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= MAX_VAL;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    // Decrement saturates at zero, so holding at zero never re-fires expired.
    always_comb begin
        count_d   = count_q;
        expired_d = 1'b0;
        if (load_i) begin
            count_d = init_i;
        end else if (en_i && (count_q != '0)) begin
            count_d   = count_q - WIDTH'(1);
            expired_d = (count_q == WIDTH'(1));
        end
    end

    assign out_o     = count_q;
    assign zero_o    = (count_q == '0);
    assign expired_o = expired_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an arithmetic reference model.
module tb_timer;

    localparam int WIDTH = 4;
    localparam int MAXV  = 15;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] init = '0;
    logic [WIDTH-1:0] outV;
    logic             zeroV;
    logic             expiredV;

    int checks = 0;
    int passed = 0;
    int modelOut = MAXV;
    int modelExp = 0;
    bit compareOn = 1'b0;
    int pulses;

    timer #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .en_i     (en),
        .load_i   (load),
        .init_i   (init),
        .out_o    (outV),
        .zero_o   (zeroV),
        .expired_o(expiredV)
    );

    always #5 clk = ~clk;

    // Reference model: count value as a plain integer.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            modelOut = MAXV;
            modelExp = 0;
        end else if (load) begin
            modelOut = int'(init);
            modelExp = 0;
        end else if (en && modelOut > 0) begin
            modelOut = modelOut - 1;
            modelExp = (modelOut == 0) ? 1 : 0;
        end else begin
            modelExp = 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("model_out", int'(outV), modelOut);
            checkOutput("model_zero", int'(zeroV), (modelOut == 0) ? 1 : 0);
            checkOutput("model_expired", int'(expiredV), modelExp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic e, input logic [WIDTH-1:0] i);
        rstN = r;
        load = l;
        en   = e;
        init = i;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        tick();
        tick();
        compareOn = 1'b1;

        // Reset then idle
        doReset();
        tick();
        checkOutput("reset_out", int'(outV), 15);
        checkOutput("reset_zero", int'(zeroV), 0);
        checkOutput("reset_expired", int'(expiredV), 0);

        // Load 4, then idle one cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd4);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("load4_out", int'(outV), 4);

        // 10 decrements from 15, then hold
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        repeat (10) tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("count10_out", int'(outV), 5);
        repeat (5) tick();
        checkOutput("hold_out", int'(outV), 5);

        // Count to zero and saturate; expired fires once at the 15th edge
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (expiredV) pulses++;
            if (k == 15) begin
                checkOutput("edge15_expired", int'(expiredV), 1);
                checkOutput("edge15_out", int'(outV), 0);
            end
        end
        checkOutput("expired_pulses", pulses, 1);
        checkOutput("saturate_out", int'(outV), 0);
        checkOutput("saturate_zero", int'(zeroV), 1);
        checkOutput("saturate_expired", int'(expiredV), 0);

        // Async reset beats enable, no clock edge needed
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        repeat (5) tick();
        checkOutput("pre_reset_out", int'(outV), 10);
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_en_out", int'(outV), 15);
        tick();

        // Async reset beats load
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd4);
        tick();
        checkOutput("load_before_reset", int'(outV), 4);
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_load_out", int'(outV), 15);
        tick();
        checkOutput("reset_held_out", int'(outV), 15);

        // Load wins over enable
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        repeat (5) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd2);
        tick();
        checkOutput("load_over_en_out", int'(outV), 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) tick();
        checkOutput("load_hold_out", int'(outV), 2);

        // Load of zero must not pulse expired
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("load0_out", int'(outV), 0);
        checkOutput("load0_expired", int'(expiredV), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 59) != 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) != 0),
                          WIDTH'($urandom_range(0, MAXV)));
            tick();
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        tick();
        compareOn = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/timer.md
Name:
timer

Overview:
- Loadable, saturating down-counter timer with a single clock domain and an asynchronous active-low reset.
- Resets to its maximum count, counts down by one per enabled cycle and stops at zero.
- Can be reloaded at any time with an arbitrary start value.
- Used as a countdown/timeout primitive; exposes the count plus zero and expiry flags for control FSMs.

Parameters:
- WIDTH, 4, bit width of the counter, init and out.
- MAX_VAL, 2**WIDTH-1, value loaded on reset (all ones by default, i.e. 15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it (0) immediately forces the reset state; deassertion is synchronous to clk.
- en  input  1  count enable; decrement by one per rising edge when asserted.
- load  input  1  synchronous load strobe; out takes init on the next rising edge.
- init  input  WIDTH  value captured when load is asserted.
- out  output  WIDTH  current count (registered).
- zero  output  1  combinational, 1 when out == 0.
- expired  output  1  registered, one-cycle pulse when the count reaches 0 by decrementing.

Behaviour:
- Reset (rst=0, asynchronous): out=MAX_VAL (15), expired=0. Held for as long as rst=0, regardless of load/en/init. Reset mid-count or mid-load aborts the operation; out=15 with no clock edge needed.
- Priority on each rising edge with rst=1: load > en > hold.
  - load=1: out<=init (any value, including 0 and MAX_VAL); en is ignored that cycle. expired<=0.
  - load=0, en=1, out>0: out<=out-1. expired<=1 iff out==1 (transition to 0), else 0.
  - load=0, en=1, out==0: out stays 0 (saturate, never wraps to MAX_VAL); expired<=0.
  - load=0, en=0: out holds its value indefinitely; expired<=0.
- Latency: load and decrement take effect one clock after the sampling edge; out is stable between edges.
- zero is pure combinational decode of out and is valid in the same cycle as out.
- expired is asserted for exactly one cycle per 1->0 transition. It is not asserted for load of 0 or while holding at 0.
- No X propagation: all registers are defined by reset; WIDTH>=1 is supported.

Test Plan:
- Reset then idle (en=0, load=0, init=0) for one cycle -> out=15, zero=0, expired=0.
- load=1, init=4 for one cycle, then load=0 and wait one cycle -> out=4.
- From reset (out=15): en=1 for 10 cycles, then en=0 for one cycle -> out=5. Continue with en=0 for 5 more cycles -> out stays 5.
- From reset: en=1 for 20 cycles -> out reaches 0 after 15 cycles and stays 0 (no wrap). expired pulses exactly once at the 15th edge; zero=1 thereafter.
- Reset precedence over enable and load:
  - Count down 5 (out=10), then assert rst=0 with en=1 -> out=15 immediately.
  - With load=1, init=4 and out=4, assert rst=0 -> out=15.
- Load over enable: count down 5 from 15 (out=10), then load=1, init=2 with en=1 -> out=2 after one edge, not 9. Then load=0, en=0 -> out holds 2.
